// File: rtl/cpu_ctrl_pkg.sv
// Shared types and instruction field layout for the multi-cycle CPU control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_ALU   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Instruction field bit positions.
  localparam int OPC_HI   = 19;
  localparam int OPC_LO   = 18;
  localparam int X1_HI    = 17;
  localparam int X1_LO    = 16;
  localparam int X2_HI    = 15;
  localparam int X2_LO    = 14;
  localparam int X3_HI    = 13;
  localparam int X3_LO    = 12;
  localparam int OFF_HI   = 11;
  localparam int OFF_LO   = 4;
  localparam int FUNC_BIT = 0;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/cpu_ctrl_sequencer_if.sv
// Instruction issue handshake between an instruction source and the control sequencer.
interface cpu_ctrl_sequencer_if #(
    parameter int INSTR_WIDTH = 20
);
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instruction;

    modport master (
        output instr_valid,
        output instruction,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instruction,
        output instr_ready
    );
endinterface

// File: rtl/cpu_instr_decode.sv
// Combinational field extraction and opcode classification of the latched instruction.
module cpu_instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int REG_BITS    = 2,
    parameter int OFF_WIDTH   = 8
) (
    input  logic [INSTR_WIDTH-1:0] i_ir,
    output opcode_e                o_opcode,
    output logic [REG_BITS-1:0]    o_x1,
    output logic [REG_BITS-1:0]    o_x2,
    output logic [REG_BITS-1:0]    o_x3,
    output logic [OFF_WIDTH-1:0]   o_offset,
    output logic                   o_func,
    output logic                   o_is_nop,
    output logic                   o_is_alu,
    output logic                   o_is_load,
    output logic                   o_is_store
);
    // Bits [3:1] carry no meaning in any instruction format.
    logic w_unused_bits;

    assign o_opcode      = opcode_e'(i_ir[OPC_HI:OPC_LO]);
    assign o_x1          = i_ir[X1_HI:X1_LO];
    assign o_x2          = i_ir[X2_HI:X2_LO];
    assign o_x3          = i_ir[X3_HI:X3_LO];
    assign o_offset      = i_ir[OFF_HI:OFF_LO];
    assign o_func        = i_ir[FUNC_BIT];
    assign w_unused_bits = ^i_ir[3:1];

    assign o_is_nop   = (o_opcode == OP_NOP);
    assign o_is_alu   = (o_opcode == OP_ALU);
    assign o_is_load  = (o_opcode == OP_LOAD);
    assign o_is_store = (o_opcode == OP_STORE);
endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Multi-cycle controller: latches one instruction and steps it through DECODE/EXEC/MEM/WB,
// driving Moore strobes to the register file, ALU and data memory.
module cpu_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int INSTR_WIDTH = 20,
    parameter int REG_BITS    = 2,
    parameter int OFF_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_ctrl_sequencer_if.slave  instr_if,
    output logic [REG_BITS-1:0]  rf_raddr_a,
    output logic [REG_BITS-1:0]  rf_raddr_b,
    output logic [REG_BITS-1:0]  rf_waddr,
    output logic                 rf_we,
    output logic                 alu_op,
    output logic                 alu_src_imm,
    output logic [OFF_WIDTH-1:0] offset,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic                 wb_sel,
    output logic                 busy,
    output logic                 instr_done,
    output logic [2:0]           state_dbg
);
    // The offset is zero-extended onto the datapath word and the address is cut from it.
    if ((OFF_WIDTH > DATA_WIDTH) || (ADDR_BITS > DATA_WIDTH)) begin : g_width_check
        $error("cpu_ctrl_sequencer: OFF_WIDTH and ADDR_BITS must not exceed DATA_WIDTH");
    end

    state_e                 r_state;
    state_e                 w_next_state;
    logic [INSTR_WIDTH-1:0] r_ir;

    opcode_e               w_opcode;
    logic [REG_BITS-1:0]   w_x1;
    logic [REG_BITS-1:0]   w_x2;
    logic [REG_BITS-1:0]   w_x3;
    logic [OFF_WIDTH-1:0]  w_offset;
    logic                  w_func;
    logic                  w_is_nop;
    logic                  w_is_alu;
    logic                  w_is_load;
    logic                  w_is_store;

    cpu_instr_decode #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .REG_BITS    (REG_BITS),
        .OFF_WIDTH   (OFF_WIDTH)
    ) u_decode (
        .i_ir       (r_ir),
        .o_opcode   (w_opcode),
        .o_x1       (w_x1),
        .o_x2       (w_x2),
        .o_x3       (w_x3),
        .o_offset   (w_offset),
        .o_func     (w_func),
        .o_is_nop   (w_is_nop),
        .o_is_alu   (w_is_alu),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && instr_if.instr_valid) begin
                r_ir <= instr_if.instruction;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state         = r_state;
        instr_if.instr_ready = 1'b0;
        rf_raddr_a           = w_x2;
        rf_raddr_b           = w_is_store ? w_x1 : w_x3;
        rf_waddr             = w_x1;
        offset               = w_offset;
        rf_we                = 1'b0;
        alu_op               = 1'b0;
        alu_src_imm          = 1'b0;
        mem_re               = 1'b0;
        mem_we               = 1'b0;
        wb_sel               = WB_ALU;
        instr_done           = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                instr_if.instr_ready = 1'b1;
                if (instr_if.instr_valid) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                instr_done   = w_is_nop;
                w_next_state = w_is_nop ? ST_IDLE : ST_EXEC;
            end
            ST_EXEC: begin
                alu_op       = w_is_alu & w_func;
                alu_src_imm  = w_is_load | w_is_store;
                w_next_state = (w_opcode == OP_ALU) ? ST_WB : ST_MEM;
            end
            ST_MEM: begin
                mem_we       = w_is_store;
                mem_re       = w_is_load;
                instr_done   = w_is_store;
                w_next_state = w_is_load ? ST_WB : ST_IDLE;
            end
            ST_WB: begin
                rf_we        = 1'b1;
                wb_sel       = w_is_load ? WB_MEM : WB_ALU;
                instr_done   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign state_dbg = r_state;
endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Bench: sequencer driving a small behavioural datapath, checked against an instruction-level model.
module tb_cpu_ctrl_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_ctrl_sequencer_if #(.INSTR_WIDTH(20)) instr_if ();

    logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic       rf_we, alu_op, alu_src_imm, mem_re, mem_we, wb_sel, busy, instr_done;
    logic [7:0] offset;
    logic [2:0] state_dbg;

    cpu_ctrl_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_if    (instr_if),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_waddr    (rf_waddr),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .offset      (offset),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .wb_sel      (wb_sel),
        .busy        (busy),
        .instr_done  (instr_done),
        .state_dbg   (state_dbg)
    );

    // Datapath driven purely by the controller strobes; pokes preload contents while idle.
    logic [7:0] dp_rf  [4];
    logic [7:0] dp_mem [32];
    logic [7:0] op_a, op_b, alu_r, mem_rd, alu_b, alu_y;
    logic       poke_rf_en = 1'b0, poke_mem_en = 1'b0;
    logic [4:0] poke_idx = '0;
    logic [7:0] poke_val = '0;

    assign alu_b = alu_src_imm ? offset : op_b;
    assign alu_y = alu_op ? (op_a - alu_b) : (op_a + alu_b);

    always @(posedge clk) begin
        op_a  <= dp_rf[rf_raddr_a];
        op_b  <= dp_rf[rf_raddr_b];
        alu_r <= alu_y;
        if (mem_re) mem_rd <= dp_mem[alu_r[4:0]];
        if (mem_we) dp_mem[alu_r[4:0]] <= op_b;
        if (rf_we) dp_rf[rf_waddr] <= wb_sel ? mem_rd : alu_r;
        if (poke_rf_en) dp_rf[poke_idx[1:0]] <= poke_val;
        if (poke_mem_en) dp_mem[poke_idx] <= poke_val;
    end

    // Reference model: architectural state updated one whole instruction at a time.
    logic [7:0] m_rf  [4];
    logic [7:0] m_mem [32];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input bit is_mem, input int idx, input logic [7:0] val);
        @(negedge clk);
        poke_rf_en  = !is_mem;
        poke_mem_en = is_mem;
        poke_idx    = 5'(idx);
        poke_val    = val;
        @(posedge clk);
        #1;
        poke_rf_en  = 1'b0;
        poke_mem_en = 1'b0;
        if (is_mem) m_mem[idx] = val;
        else        m_rf[idx]  = val;
    endtask

    task automatic run_instr(input logic [19:0] ins, input bit hold_valid, input string tag);
        logic [1:0] opc, x1, x2, x3;
        logic [7:0] off;
        logic       func;
        int         exp_lat, exp_rfwe, exp_mwe, exp_mre, ea;
        int         edges, k, done_edge, n_rfwe, n_mwe, n_mre, n_done, n_excl, n_rdy;
        bit         finished;
        logic [31:0] dec_a, dec_b, dec_st, ex_op, ex_imm, ex_off, ex_st, wb_addr, wb_s;

        opc = ins[19:18]; x1 = ins[17:16]; x2 = ins[15:14]; x3 = ins[13:12];
        off = ins[11:4];  func = ins[0];
        ea  = (int'(m_rf[x2]) + int'(off)) % 32;
        exp_lat  = (opc == 2'd0) ? 2 : (opc == 2'd2) ? 5 : 4;
        exp_rfwe = (opc == 2'd1 || opc == 2'd2) ? 1 : 0;
        exp_mwe  = (opc == 2'd3) ? 1 : 0;
        exp_mre  = (opc == 2'd2) ? 1 : 0;
        {dec_a, dec_b, dec_st, ex_op, ex_imm, ex_off, ex_st, wb_addr, wb_s} = {9{32'hxxxx_xxxx}};
        n_rfwe = 0; n_mwe = 0; n_mre = 0; n_done = 0; n_excl = 0; n_rdy = 0;
        done_edge = 0; finished = 0; k = 0;

        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, instr_if.instr_ready}, 32'd1);
        instr_if.instruction = ins;
        instr_if.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        edges = 1;
        instr_if.instruction = 20'($urandom);
        if (!hold_valid) instr_if.instr_valid = 1'b0;

        while (!finished && k < 12) begin
            @(negedge clk);
            if (rf_we) begin n_rfwe++; wb_addr = 32'(rf_waddr); wb_s = 32'(wb_sel); end
            if (mem_we) n_mwe++;
            if (mem_re) n_mre++;
            if (int'(rf_we) + int'(mem_we) + int'(mem_re) > 1) n_excl++;
            if (instr_if.instr_ready) n_rdy++;
            if (k == 0) begin dec_a = 32'(rf_raddr_a); dec_b = 32'(rf_raddr_b); dec_st = 32'(state_dbg); end
            if (k == 1) begin
                ex_op = 32'(alu_op); ex_imm = 32'(alu_src_imm); ex_off = 32'(offset); ex_st = 32'(state_dbg);
            end
            if (instr_done) begin
                n_done++;
                done_edge = edges + 1;
                finished  = 1'b1;
            end
            k++;
            @(posedge clk);
            #1;
            edges++;
        end

        @(negedge clk);
        check({tag, "_finished"}, {31'd0, finished}, 32'd1);
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, instr_if.instr_ready}, 32'd1);
        instr_if.instr_valid = 1'b0;

        check({tag, "_latency"}, 32'(done_edge), 32'(exp_lat));
        check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
        check({tag, "_rf_we_cnt"}, 32'(n_rfwe), 32'(exp_rfwe));
        check({tag, "_mem_we_cnt"}, 32'(n_mwe), 32'(exp_mwe));
        check({tag, "_mem_re_cnt"}, 32'(n_mre), 32'(exp_mre));
        check({tag, "_exclusive"}, 32'(n_excl), 32'd0);
        check({tag, "_ready_busy"}, 32'(n_rdy), 32'd0);
        check({tag, "_dec_state"}, dec_st, 32'd1);
        check({tag, "_raddr_a"}, dec_a, 32'(x2));
        check({tag, "_raddr_b"}, dec_b, (opc == 2'd3) ? 32'(x1) : 32'(x3));
        if (opc != 2'd0) begin
            check({tag, "_exec_state"}, ex_st, 32'd2);
            check({tag, "_alu_op"}, ex_op, (opc == 2'd1) ? 32'(func) : 32'd0);
            check({tag, "_alu_src_imm"}, ex_imm, (opc[1]) ? 32'd1 : 32'd0);
            check({tag, "_offset"}, ex_off, 32'(off));
        end
        if (exp_rfwe == 1) begin
            check({tag, "_waddr"}, wb_addr, 32'(x1));
            check({tag, "_wb_sel"}, wb_s, (opc == 2'd2) ? 32'd1 : 32'd0);
        end

        case (opc)
            2'd1: m_rf[x1] = func ? (m_rf[x2] - m_rf[x3]) : (m_rf[x2] + m_rf[x3]);
            2'd2: m_rf[x1] = m_mem[ea];
            2'd3: m_mem[ea] = m_rf[x1];
            default: ;
        endcase
        for (int i = 0; i < 4; i++) check($sformatf("%s_rf%0d", tag, i), 32'(dp_rf[i]), 32'(m_rf[i]));
        if (opc[1]) check($sformatf("%s_mem%0d", tag, ea), 32'(dp_mem[ea]), 32'(m_mem[ea]));
    endtask

    // Abort an instruction with reset after n_edges edges; pre_exp is {alu_src_imm, mem_we} just before.
    task automatic reset_during(input logic [19:0] ins, input int n_edges, input logic [1:0] pre_exp,
                                input string tag);
        int ea;
        ea = (int'(m_rf[ins[15:14]]) + int'(ins[11:4])) % 32;
        @(negedge clk);
        instr_if.instruction = ins;
        instr_if.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_if.instr_valid = 1'b0;
        repeat (n_edges - 1) @(posedge clk);
        #2;
        check({tag, "_pre"}, {30'd0, alu_src_imm, mem_we}, {30'd0, pre_exp});
        rst_n = 1'b0;
        #1;
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_strobes"}, {26'd0, rf_we, mem_we, mem_re, instr_done, alu_src_imm, alu_op}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, "_ready_rel"}, {31'd0, instr_if.instr_ready}, 32'd1);
        repeat (3) @(posedge clk);
        check({tag, "_no_write"}, 32'(dp_mem[ea]), 32'(m_mem[ea]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] rnd;
        rst_n = 1'b0;
        instr_if.instr_valid = 1'b0;
        instr_if.instruction = '0;
        #1;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobes", {26'd0, rf_we, mem_we, mem_re, instr_done, alu_src_imm, wb_sel}, 32'd0);
        #11;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, instr_if.instr_ready}, 32'd1);

        for (int i = 0; i < 4; i++) poke(1'b0, i, 8'(i));
        for (int i = 0; i < 32; i++) poke(1'b1, i, 8'($urandom));

        reset_during(20'b11010000000000100000, 2, 2'b10, "rst_exec");
        reset_during(20'b11010000000000100000, 3, 2'b01, "rst_mem");

        run_instr(20'b01000111000000000000, 1'b0, "add");
        run_instr(20'b01110010000000000001, 1'b1, "sub");
        run_instr(20'b01011100000000000001, 1'b0, "sub_neg");
        poke(1'b0, 1, 8'd7);
        poke(1'b0, 2, 8'd2);
        run_instr(20'b11011000000011110000, 1'b0, "store");
        check("store_mem17", 32'(dp_mem[17]), 32'd7);
        run_instr(20'b10111000000011110000, 1'b1, "load");
        check("load_reg3", 32'(dp_rf[3]), 32'd7);
        poke(1'b0, 0, 8'd31);
        run_instr(20'b11010000000000100000, 1'b0, "wrap");
        check("wrap_mem1", 32'(dp_mem[1]), 32'd7);
        run_instr(20'h00000, 1'b0, "nop");

        for (int n = 0; n < 40; n++) begin
            rnd = 20'($urandom);
            run_instr(rnd, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        for (int i = 0; i < 32; i++) check($sformatf("final_mem%0d", i), 32'(dp_mem[i]), 32'(m_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl_sequencer.md
Name: cpu_ctrl_sequencer

Overview:
- Multi-cycle control unit for the 8-bit simple CPU datapath: register file (4×8), add/sub ALU, 32-entry data memory.
- Accepts one 20-bit instruction at a time over a valid/ready handshake and latches it.
- Sequences the instruction through DECODE/EXEC/MEM/WB by driving the datapath strobes.
- Pulses done on completion; replaces the hand-timed instruction holding currently needed to drive the CPU.

Parameters:
- DATA_WIDTH, 8, datapath word width (passed through for the offset zero-extend width check).
- ADDR_BITS, 5, data memory address width.
- INSTR_WIDTH, 20, instruction width.
- REG_BITS, 2, register index width.
- OFF_WIDTH, 8, load/store offset width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instruction  in  INSTR_WIDTH  [19:18] opcode (00 NOP, 01 ALU, 10 LOAD, 11 STORE); [17:16] X1; [15:14] X2; [13:12] X3; [11:4] offset; [0] func (0 ADD, 1 SUB)
- rf_raddr_a  out  REG_BITS  read port A = X2
- rf_raddr_b  out  REG_BITS  read port B = X3 (ALU) or X1 (STORE data)
- rf_waddr  out  REG_BITS  write index = X1
- rf_we  out  1  register write strobe
- alu_op  out  1  0 add, 1 sub
- alu_src_imm  out  1  1: ALU B operand = zero-extended offset
- offset  out  OFF_WIDTH  latched offset field
- mem_re  out  1  data memory read strobe (synchronous read)
- mem_we  out  1  data memory write strobe
- wb_sel  out  1  0 ALU result, 1 memory data
- busy  out  1  not in IDLE
- instr_done  out  1  one-cycle completion pulse
- state_dbg  out  3  current state encoding

Behaviour:
- FSM states: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Reset (async, rst_n=0):
  - state=IDLE, IR=0.
  - All strobes 0; instr_ready=1 after release; busy=0, instr_done=0, state_dbg=0.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at an edge: IR<=instruction; go to DECODE.
  - Otherwise hold.
- DECODE:
  - rf_raddr_a/b driven from IR; datapath registers operands at end of cycle.
  - NOP: instr_done=1, then IDLE.
  - Else: go to EXEC.
- EXEC:
  - ALU: alu_op=IR[0], alu_src_imm=0; then WB.
  - LOAD/STORE: alu_op=0, alu_src_imm=1; address = (reg[X2]+offset) truncated to ADDR_BITS (wraps mod 32, e.g. 31+2 → 1); then MEM.
- MEM:
  - STORE: mem_we=1 for exactly this cycle, instr_done=1; then IDLE.
  - LOAD: mem_re=1; then WB.
- WB:
  - rf_we=1, rf_waddr=X1, wb_sel=1 for LOAD and 0 for ALU.
  - instr_done=1; then IDLE.
- Latency, in rising edges from the accept edge to the edge that commits the result:
  - NOP 2, ALU 4, STORE 4, LOAD 5.
- Strobe exclusivity: rf_we, mem_we and mem_re are mutually exclusive, never asserted together.
- instr_ready is 1 only in IDLE. The instruction input is ignored while busy; later changes do not affect the latched IR.
- Next accept occurs no earlier than the cycle after instr_done.
- ALU arithmetic is mod 2^DATA_WIDTH in the datapath (4-2=2; 2-4=0xFE); the controller performs no arithmetic.
- Reset asserted mid-instruction:
  - Immediate return to IDLE; strobes drop asynchronously.
  - No partial register or memory write.
- Unused IR bits ([3:1] for ALU, [13:12] for LOAD/STORE) are ignored.
- Outputs are a pure function of state and IR (Moore); no combinational path from instr_valid to strobes.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants OP_NOP/OP_ALU/OP_LOAD/OP_STORE;
  - state enum;
  - field bit positions for OPC, X1, X2, X3, OFF, FUNC;
  - WB_ALU/WB_MEM constants.
- Sub-module cpu_instr_decode (combinational): IR → opcode, register indices, offset, func, is_load/is_store/is_alu/is_nop.

Test Plan:
- Reset mid-EXEC: assert rst_n=0 → state IDLE within the same cycle, all strobes 0; after release, instr_ready=1.
- ADD 20'b01000111000000000000 with regfile [0,1,2,3]:
  - rf_raddr_a=1 and rf_raddr_b=3 in DECODE;
  - rf_we=1, rf_waddr=0, wb_sel=0 on the 4th edge;
  - reg0=4; instr_done pulses once.
- SUB 20'b01110010000000000001 after reg0=4: alu_op=1 in EXEC → reg3=2; instr_valid held high while busy → no second accept until after done.
- STORE 20'b11011000000011110000 (reg1=7, reg2=2):
  - alu_src_imm=1, offset=15;
  - mem_we=1 for exactly one cycle; mem[17]=7; rf_we never asserted.
- LOAD 20'b10111000000011110000: mem_re=1 in MEM, then rf_we=1 with wb_sel=1, rf_waddr=3 → reg3=7, 5 edges total.
- Address wrap and NOP:
  - STORE with reg[X2]=31, offset=2 → datapath address 1;
  - NOP 20'h00000 → instr_done two edges after accept, no strobes asserted.
